// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared 1-bit full adder walks two WIDTH-bit
// operands LSB first, one bit per clock, behind a start/busy/done handshake.

module fa_structural (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g, t;

  assign p    = x ^ y;
  assign g    = x & y;
  assign t    = p & cin;
  assign s    = p ^ cin;
  assign cout = g | t;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;

  fa_structural u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the top so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_psum1
      assign psum_nxt = fa_s;
    end else begin : g_psumn
      assign psum_nxt = {fa_s, psum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            psum  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (clear) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= psum_nxt;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the completing edge.
            if (cnt == LAST) begin
              sum   <= psum_nxt;
              cout  <= fa_co;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep,
// checked against plain-arithmetic expectations of a + b + cin.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4, clear4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  // Reference model state: the result the DUT should currently be holding.
  logic [7:0] exp_sum;
  logic       exp_cout;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .clear(clear4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // One full WIDTH=8 operation; disturb scrambles start/operands while busy and
  // holds start high through DONE, none of which may change the result.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit disturb);
    logic [8:0] full;
    full = 9'(av) + 9'(bv) + 9'(cv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL run_busy cycle %0d: busy/done=%b expected 10", k, {busy, done});
      end
      checks++;
      if ({cout, sum} !== {exp_cout, exp_sum}) begin
        errors++;
        $display("FAIL run_hold cycle %0d: result=%h expected %h", k, {cout, sum}, {exp_cout, exp_sum});
      end
      if (disturb) begin
        start = (k == 1) ? 1'b1 : 1'($urandom);
        a     = (k == 1) ? 8'h00 : 8'($urandom);
        b     = (k == 1) ? 8'h00 : 8'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    exp_sum  = full[7:0];
    exp_cout = full[8];
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse: busy/done=%b expected 01", {busy, done});
    end
    checks++;
    if ({cout, sum} !== {exp_cout, exp_sum}) begin
      errors++;
      $display("FAIL result %h+%h+%b: got %h expected %h", av, bv, cv, {cout, sum}, {exp_cout, exp_sum});
    end
    start = disturb;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_done: busy/done=%b expected 00", {busy, done});
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; clear = 0; cin = 0; a = 0; b = 0;
    start4 = 0; clear4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    exp_sum = '0; exp_cout = 1'b0;
    #12;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy,done,cout,sum=%h expected 0", {busy, done, cout, sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    checks++;
    if ({cout, sum} !== 9'h096) begin
      errors++;
      $display("FAIL basic_5A_3C: got %h expected 096", {cout, sum});
    end
  endtask

  task automatic test_carry();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    checks++;
    if ({cout, sum} !== 9'h1FF) begin
      errors++;
      $display("FAIL carry_FF_FF_1: got %h expected 1FF", {cout, sum});
    end
  endtask

  task automatic test_start_ignored();
    run_op(8'hA7, 8'h6B, 1'b1, 1'b1);
    run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] av, bv;
    logic       cv;
    logic [8:0] full;
    av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    for (int op = 0; op < 3; op++) begin
      full = 9'(av) + 9'(bv) + 9'(cv);
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_busy op %0d cycle %0d: busy/done=%b expected 10", op, k, {busy, done});
        end
      end
      @(negedge clk);
      exp_sum = full[7:0]; exp_cout = full[8];
      checks++;
      if ({busy, done, cout, sum} !== {2'b01, exp_cout, exp_sum}) begin
        errors++;
        $display("FAIL b2b_done op %0d: got %h expected %h", op, {busy, done, cout, sum}, {2'b01, exp_cout, exp_sum});
      end
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
      a = av; b = bv; cin = cv;
      if (op == 2) start = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_idle op %0d: busy/done=%b expected 00", op, {busy, done});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_stop: busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_clear();
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== {2'b00, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL clear_abort: got %h expected 1FF with busy/done 00", {busy, done, cout, sum});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, cout, sum} !== {2'b00, 1'b1, 8'hFF}) begin
        errors++;
        $display("FAIL clear_quiet cycle %0d: got %h expected 1FF idle", k, {busy, done, cout, sum});
      end
    end
    // start and clear together in IDLE: the start is accepted
    start = 1'b1; clear = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0; clear = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_start_idle: busy=%b expected 1", busy);
    end
    for (int k = 2; k <= 8; k++) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    // clear during DONE must not disturb anything
    clear = 1'b1;
    exp_sum = 8'h46; exp_cout = 1'b0;
    checks++;
    if ({done, cout, sum} !== {1'b1, exp_cout, exp_sum}) begin
      errors++;
      $display("FAIL clear_start_result: got %h expected 146", {done, cout, sum});
    end
    @(negedge clk); clear = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== {2'b00, exp_cout, exp_sum}) begin
      errors++;
      $display("FAIL clear_in_done: got %h expected 046 idle", {busy, done, cout, sum});
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_sum = '0; exp_cout = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {busy, done, cout, sum});
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b1, 1'b0);
    checks++;
    if ({cout, sum} !== 9'h003) begin
      errors++;
      $display("FAIL post_reset_op: got %h expected 003", {cout, sum});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_exhaustive4();
    logic [8:0] v;
    logic [4:0] full;
    int n;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      full = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      @(negedge clk);
      start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
      @(posedge clk);
      n = 0;
      do begin
        @(negedge clk);
        start4 = 1'b0;
        n++;
      end while (done4 !== 1'b1 && n < 12);
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL w4_latency %h+%h+%b: done after %0d edges expected 4", v[3:0], v[7:4], v[8], n - 1);
      end
      checks++;
      if ({cout4, sum4} !== full) begin
        errors++;
        $display("FAIL w4_result %h+%h+%b: got %h expected %h", v[3:0], v[7:4], v[8], {cout4, sum4}, full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_back_to_back();
    test_clear();
    test_reset_midrun();
    test_random();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
